// File: rtl/univ_shift_register.sv
// univ_shift_register: WIDTH-bit register with enable, parallel load, shift, rotate and up/down count.
// wrap pulses for one cycle after the counter rolls over in either direction.
module univ_shift_register #(
    parameter int          WIDTH       = 8,
    parameter logic [63:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_left,
    input  logic             sin_right,
    output logic [WIDTH-1:0] q,
    output logic             sout_left,
    output logic             sout_right,
    output logic             zero,
    output logic             wrap
);
    logic [WIDTH-1:0] q_q, q_d, shl, shr, rol, ror;
    logic             wrap_q, wrap_d;
    // A one-bit register has nothing to rotate and shifts are just the serial input.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shl = sin_right;
            assign shr = sin_left;
            assign rol = q_q;
            assign ror = q_q;
        end else begin : g_wn
            assign shl = {q_q[WIDTH-2:0], sin_right};
            assign shr = {sin_left, q_q[WIDTH-1:1]};
            assign rol = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            assign ror = {q_q[0], q_q[WIDTH-1:1]};
        end
    endgenerate
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (en) begin
            case (mode)
                3'd1:    q_d = d;
                3'd2:    q_d = shl;
                3'd3:    q_d = shr;
                3'd4:    q_d = rol;
                3'd5:    q_d = ror;
                3'd6:    q_d = q_q + 1'b1;
                3'd7:    q_d = q_q - 1'b1;
                default: q_d = q_q;
            endcase
            wrap_d = (mode == 3'd6 && &q_q) || (mode == 3'd7 && q_q == '0);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= RESET_VALUE[WIDTH-1:0];
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end
    assign q          = q_q;
    assign sout_left  = q_q[WIDTH-1];
    assign sout_right = q_q[0];
    assign zero       = (q_q == '0);
    assign wrap       = wrap_q;
endmodule
